// File: rtl/core_pkg.sv
// Shared integer-core types: register address width, data width and the
// write-back entry that carries a destination register and its result.
package core_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending long-latency write-back entries; head is read straight
// from registered storage, so an entry pushed this cycle is poppable next cycle.
module wb_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  wb_entry_t                    push_entry,
   input  logic                         pop,
   output wb_entry_t                    head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (do_push && !do_pop)
            count_reg <= count_reg + CNT_W'(1);
         else if (!do_push && do_pop)
            count_reg <= count_reg - CNT_W'(1);
      end
   end

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= push_entry;
   end

   assign head  = mem[rd_ptr_reg];
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;
endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write-port arbiter: ALU results take priority over queued
// long-latency results; a scoreboard tracks outstanding destinations for decode.
module regfile_writeback_ctrl
   import core_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = core_pkg::XLEN
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   input  logic [4:0]            alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  ll_valid,
   output logic                  ll_ready,
   input  logic [4:0]            ll_rd,
   input  logic [XLEN-1:0]       ll_data,
   input  logic                  issue_valid,
   input  logic [4:0]            issue_rd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [4:0]            rd_dec,
   output logic                  hazard,
   output logic                  alu_stall,
   output logic [NUM_REGS-1:0]   busy_vec,
   output logic                  RegWrite,
   output logic [4:0]            Rd,
   output logic [XLEN-1:0]       Write_data
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_entry_t           fifo_head;
   wb_entry_t           push_entry;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic                push;
   logic                pop;
   logic                alu_write;
   logic [NUM_REGS-1:0] busy_reg;
   logic [NUM_REGS-1:0] busy_next;
   logic                reg_write_reg;
   logic [4:0]          rd_reg;
   logic [XLEN-1:0]     write_data_reg;

   assign ll_ready   = !fifo_full && !reset;
   assign alu_stall  = (fifo_count == CNT_W'(DEPTH));
   assign push_entry = '{rd: ll_rd, data: ll_data};
   // Results for x0 are accepted but never queued.
   assign push       = ll_valid && ll_ready && (ll_rd != '0);
   // Any ALU-valid cycle owns the write slot, even a discarded x0 result.
   assign pop        = !alu_valid && !fifo_empty;
   assign alu_write  = alu_valid && (alu_rd != '0);

   wb_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   assign busy_next[0] = 1'b0;
   for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign set_hit = issue_valid && (issue_rd == REG_ADDR_W'(gi));
      assign clr_hit = pop && (fifo_head.rd == REG_ADDR_W'(gi));
      // A new issue to the same register outranks the retiring entry.
      assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
   end

   always_ff @(posedge clk) begin
      if (reset)
         busy_reg <= '0;
      else
         busy_reg <= busy_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_reg  <= 1'b0;
         rd_reg         <= '0;
         write_data_reg <= '0;
      end else if (alu_write) begin
         reg_write_reg  <= 1'b1;
         rd_reg         <= alu_rd;
         write_data_reg <= alu_data;
      end else if (pop) begin
         reg_write_reg  <= 1'b1;
         rd_reg         <= fifo_head.rd;
         write_data_reg <= fifo_head.data;
      end else begin
         reg_write_reg  <= 1'b0;
      end
   end

   assign hazard     = busy_reg[rs1] | busy_reg[rs2] | busy_reg[rd_dec];
   assign busy_vec   = busy_reg;
   assign RegWrite   = reg_write_reg;
   assign Rd         = rd_reg;
   assign Write_data = write_data_reg;
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed plus random bench for regfile_writeback_ctrl against a queue-based
// model of the write-back rules.
module tb_regfile_writeback_ctrl;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ll_valid;
   logic        ll_ready;
   logic [4:0]  ll_rd;
   logic [31:0] ll_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd_dec;
   logic        hazard;
   logic        alu_stall;
   logic [31:0] busy_vec;
   logic        RegWrite;
   logic [4:0]  Rd;
   logic [31:0] Write_data;

   ent_t        pend_q[$];
   logic [31:0] m_busy;
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   int          tests = 0;
   int          fails = 0;
   bit          verbose = 1'b1;

   always #5 clk = ~clk;

   regfile_writeback_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1(rs1), .rs2(rs2), .rd_dec(rd_dec),
      .hazard(hazard), .alu_stall(alu_stall), .busy_vec(busy_vec),
      .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ll_valid = 0; ll_rd = 0; ll_data = 0;
      issue_valid = 0; issue_rd = 0;
      rs1 = 0; rs2 = 0; rd_dec = 0;
   endtask

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic step();
      int   sz;
      ent_t e;
      #1;
      sz = pend_q.size();
      chk("ll_ready", ll_ready, !reset && (sz < DEPTH));
      chk("alu_stall", alu_stall, sz == DEPTH);
      chk("hazard", hazard, m_busy[rs1] | m_busy[rs2] | m_busy[rd_dec]);
      if (reset) begin
         pend_q.delete();
         m_busy = '0; m_we = 0; m_rd = 0; m_data = 0;
      end else begin
         m_we = 0;
         if (alu_valid) begin
            if (alu_rd != 0) begin
               m_we = 1; m_rd = alu_rd; m_data = alu_data;
            end
         end else if (sz > 0) begin
            e = pend_q.pop_front();
            m_we = 1; m_rd = e.rd; m_data = e.data;
            m_busy[e.rd] = 1'b0;
         end
         if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
         if (ll_valid && sz < DEPTH && ll_rd != 0) pend_q.push_back('{rd: ll_rd, data: ll_data});
      end
      @(posedge clk);
      #1;
      chk("RegWrite", RegWrite, m_we);
      chk("Rd", Rd, m_rd);
      chk("Write_data", Write_data, m_data);
      chk("busy_vec", busy_vec, m_busy);
      if (verbose && RegWrite)
         $display("[TB] write rd=%0d data=%08h pending=%0d", Rd, Write_data, pend_q.size());
   endtask

   initial begin
      m_busy = '0; m_we = 0; m_rd = 0; m_data = 0;
      idle();
      reset = 1;
      @(posedge clk); #1;
      step(); step();
      reset = 0;

      // Single ALU write
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      step();
      chk("alu_rd5", Rd, 5'd5);
      chk("alu_data", Write_data, 32'hDEADBEEF);
      idle();

      // Load path with hazard on rs1
      issue_valid = 1; issue_rd = 7;
      step();
      chk("busy7_set", busy_vec[7], 1'b1);
      idle(); rs1 = 7;
      step();
      chk("hazard_rs1", hazard, 1'b1);
      ll_valid = 1; ll_rd = 7; ll_data = 32'h1234;
      step();
      chk("no_fallthrough", RegWrite, 1'b0);
      idle(); rs1 = 7;
      step();
      chk("ll_write", {RegWrite, Rd, Write_data}, {1'b1, 5'd7, 32'h1234});
      chk("busy7_clr", busy_vec[7], 1'b0);
      idle();

      // Priority: ALU holds the port while two entries wait
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'hA000 + i;
         ll_valid = (i < 2); ll_rd = 5'(20 + i); ll_data = 32'hB000 + i;
         step();
      end
      idle();
      for (int i = 0; i < 3; i++) step();

      // Fill the FIFO under continuous ALU traffic, then drain
      for (int i = 0; i < 5; i++) begin
         alu_valid = 1; alu_rd = 3; alu_data = 32'hC000 + i;
         ll_valid = 1; ll_rd = 5'(1 + i); ll_data = 32'hD000 + i;
         step();
      end
      chk("full_stall", alu_stall, 1'b1);
      chk("full_ready", ll_ready, 1'b0);
      idle();
      for (int i = 0; i < 6; i++) step();

      // x0 writes are never committed
      alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
      ll_valid = 1; ll_rd = 0; ll_data = 32'hEEEE;
      issue_valid = 1; issue_rd = 0;
      for (int i = 0; i < 3; i++) step();
      chk("x0_nowrite", RegWrite, 1'b0);
      chk("x0_busy", busy_vec[0], 1'b0);
      idle();

      // Reset with entries pending and x5/x7 busy
      issue_valid = 1; issue_rd = 5; step();
      issue_rd = 7; step();
      issue_valid = 0;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1; alu_rd = 2; alu_data = 32'h5;
         ll_valid = 1; ll_rd = 5'(9 + i); ll_data = 32'hE000 + i;
         step();
      end
      chk("busy_a0", busy_vec, 32'h0000_00A0);
      idle(); alu_valid = 1; alu_rd = 2;
      reset = 1; step();
      reset = 0; idle();
      chk("rst_busy", busy_vec, 32'h0);
      for (int i = 0; i < 3; i++) step();
      chk("rst_nowrite", RegWrite, 1'b0);

      // Randomized traffic against the model
      verbose = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         reset       = ($urandom_range(0, 199) == 0);
         alu_valid   = ($urandom_range(0, 99) < 40);
         alu_rd      = 5'($urandom_range(0, 31));
         alu_data    = $urandom;
         ll_valid    = ($urandom_range(0, 99) < 60);
         ll_rd       = 5'($urandom_range(0, 31));
         ll_data     = $urandom;
         issue_valid = ($urandom_range(0, 99) < 50);
         issue_rd    = 5'($urandom_range(0, 31));
         rs1         = 5'($urandom_range(0, 31));
         rs2         = 5'($urandom_range(0, 31));
         rd_dec      = 5'($urandom_range(0, 31));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/regfile_writeback_ctrl.md
# regfile_writeback_ctrl

Write-side controller for the integer register file: merges single-cycle ALU results and long-latency results (loads, multiply/divide) onto the register file's single write port (RegWrite/Rd/Write_data). A small FIFO holds pending long-latency results, a 32-bit scoreboard tracks destination registers with results still outstanding, and a combinational hazard output lets the decode stage stall on RAW/WAW conflicts.

## Interface
- DEPTH, 4, long-latency result FIFO entries (power of two, ≥2)
- XLEN, 32, data width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result valid this cycle (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ll_valid  in  1  long-latency result offered
- ll_ready  out  1  FIFO can accept; = !full && !reset
- ll_rd  in  5  long-latency destination
- ll_data  in  XLEN  long-latency result
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  its destination register
- rs1, rs2  in  5  decode-stage source registers
- rd_dec  in  5  decode-stage destination register
- hazard  out  1  decode must stall
- alu_stall  out  1  FIFO full; upstream must hold alu_valid low
- busy_vec  out  32  scoreboard, bit n = xn pending
- RegWrite  out  1  register file write enable
- Rd  out  5  register file write address
- Write_data  out  XLEN  register file write data

## Operation
- Accept: ll_valid && ll_ready pushes {ll_rd, ll_data}; ll_rd==0 is accepted and discarded (no push).
- Commit select each cycle: alu_valid && alu_rd!=0 → ALU wins; else FIFO non-empty → pop head; else no write.
- alu_valid with alu_rd==0: no write, and FIFO may not pop that cycle (ALU slot consumed).
- Selected write registered into RegWrite/Rd/Write_data; RegWrite=0 cycles hold Rd/Write_data at previous values.
- Scoreboard: issue_valid && issue_rd!=0 sets busy[issue_rd]; FIFO pop clears busy[popped rd]. Same rd set and cleared same cycle → set wins. busy[0] constant 0.
- hazard = busy[rs1] | busy[rs2] | busy[rd_dec] (x0 ignored via busy[0]=0).
- alu_stall = (count == DEPTH). If alu_valid arrives while full, ALU still wins; FIFO holds (no loss, no pop).
- Push at full never occurs (ll_ready low); push and pop same cycle at non-full: count unchanged.
- Pointers wrap modulo DEPTH; count width clog2(DEPTH+1).

## Timing
- Reset (synchronous): RegWrite=0, Rd=0, Write_data=0, FIFO empty (count=0, pointers 0), busy_vec=0, ll_ready=0, alu_stall=0, hazard=0 unless inputs force via cleared scoreboard (→0).
- Reset mid-operation: all pending FIFO entries and busy bits dropped at the reset edge; no write issued.
- ALU latency: alu_valid in cycle N → RegWrite=1 in cycle N+1.
- Long-latency latency: pushed at edge ending cycle N → earliest pop/RegWrite in cycle N+2 (no fall-through).
- Busy clear visible in busy_vec/hazard the same cycle RegWrite for that entry is high.
- ll_ready, alu_stall derived from registered count only (no combinational path from ll_valid or alu_valid).
- hazard is combinational from rs1/rs2/rd_dec and registered busy_vec.

## Structure
- Shared package (core_pkg): XLEN, REG_ADDR_W=5, NUM_REGS=32, wb_entry_t {rd[4:0], data[XLEN-1:0]}.
- One sub-module: wb_fifo (parameter DEPTH, entry type wb_entry_t, push/pop/full/empty/count, head output registered-storage read).
- Top holds arbitration, scoreboard, output registers.

## Test plan
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF → next cycle RegWrite=1, Rd=5, Write_data=0xDEADBEEF.
- Load path: issue_rd=7 → busy_vec[7]=1, hazard with rs1=7; push ll_rd=7, 0x1234 with ALU idle → RegWrite Rd=7 two cycles later, busy_vec[7]=0 same cycle.
- Priority: ALU valid every cycle for 3 cycles while 2 FIFO entries pending → 3 ALU writes, then FIFO entries in order.
- Full: 4 pushes with alu_valid continuously high → count=4, ll_ready=0, alu_stall=1; drop alu_valid → pops restore ll_ready next cycle.
- x0: alu_rd=0 and ll_rd=0 → RegWrite never asserted, count unchanged, busy_vec[0]=0.
- Reset with 3 entries pending and busy_vec=0x000000A0 → next cycle count=0, busy_vec=0, RegWrite=0, no pending writes afterwards.
